// File: rtl/clock_set_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | clock_set_pkg: shared types and field layout for the clock setter   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package clock_set_pkg;

  localparam int TIME_W   = 17;
  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int SEC_MAX  = 59;

  localparam int HOUR_HI = 16;
  localparam int HOUR_LO = 12;
  localparam int MIN_HI  = 11;
  localparam int MIN_LO  = 6;
  localparam int SEC_HI  = 5;
  localparam int SEC_LO  = 0;

  localparam logic [1:0] FSEL_NONE = 2'd0;
  localparam logic [1:0] FSEL_HOUR = 2'd1;
  localparam logic [1:0] FSEL_MIN  = 2'd2;
  localparam logic [1:0] FSEL_SEC  = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EDIT_H = 3'd1,
    EDIT_M = 3'd2,
    EDIT_S = 3'd3,
    COMMIT = 3'd4
  } state_t;

  function automatic logic [1:0] field_of(state_t s);
    case (s)
      EDIT_H:  return FSEL_HOUR;
      EDIT_M:  return FSEL_MIN;
      EDIT_S:  return FSEL_SEC;
      default: return FSEL_NONE;
    endcase
  endfunction

  function automatic logic is_edit(state_t s);
    return (s == EDIT_H) || (s == EDIT_M) || (s == EDIT_S);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_set_ctrl_field_stepper.sv
// +--------------------------------------------------------------------+
// | field_stepper: +/-1 with wrap for one time field (combinational)    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module field_stepper #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic [WIDTH-1:0] value,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] next_value
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  // Out-of-range captured values snap to 0 on up and MAX on down.
  always_comb begin
    next_value = value;
    if (up && !down) begin
      next_value = (value >= MAX_V) ? '0 : value + WIDTH'(1);
    end else if (down && !up) begin
      next_value = ((value == '0) || (value > MAX_V)) ? MAX_V : value - WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/clock_set_ctrl.sv
// +--------------------------------------------------------------------+
// | clock_set_ctrl: edit/commit sequencer for the time-keeping counter  |
// | Optional idle auto-abort: define CLOCK_SET_TIMEOUT_EN. Revision 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int OW_CYC      = 4,
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_mode,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_cancel,
  input  logic [TIME_W-1:0] time_current,
  output logic [TIME_W-1:0] time_set,
  output logic              time_ow,
  output logic [TIME_W-1:0] time_disp,
  output logic [1:0]        field_sel,
  output logic              edit_active
);

  localparam int              OW_W    = $clog2(OW_CYC + 1);
  localparam logic [OW_W-1:0] OW_LAST = OW_W'(OW_CYC - 1);

  state_t              state;
  state_t              state_nx;
  logic [TIME_W-1:0]   edit_nx;
  logic [OW_W-1:0]     ow_cnt;
  logic                timeout_hit;

  logic [HOUR_HI-HOUR_LO:0] hour_nx;
  logic [MIN_HI-MIN_LO:0]   min_nx;
  logic [SEC_HI-SEC_LO:0]   sec_nx;

  field_stepper #(.WIDTH(HOUR_HI - HOUR_LO + 1), .MAX(HOUR_MAX)) u_hour (
    .value      (time_set[HOUR_HI:HOUR_LO]),
    .up         (btn_up),
    .down       (btn_down),
    .next_value (hour_nx)
  );

  field_stepper #(.WIDTH(MIN_HI - MIN_LO + 1), .MAX(MIN_MAX)) u_min (
    .value      (time_set[MIN_HI:MIN_LO]),
    .up         (btn_up),
    .down       (btn_down),
    .next_value (min_nx)
  );

  field_stepper #(.WIDTH(SEC_HI - SEC_LO + 1), .MAX(SEC_MAX)) u_sec (
    .value      (time_set[SEC_HI:SEC_LO]),
    .up         (btn_up),
    .down       (btn_down),
    .next_value (sec_nx)
  );

`ifdef CLOCK_SET_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        any_btn;

  assign any_btn     = btn_mode | btn_up | btn_down | btn_cancel;
  assign timeout_hit = (to_cnt == 32'(TIMEOUT_CYC - 1)) && !any_btn;

  // Cleared outside edit states, so entry into EDIT_H always starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (is_edit(state) && !any_btn) begin
      to_cnt <= to_cnt + 32'd1;
    end else begin
      to_cnt <= '0;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^32'(TIMEOUT_CYC);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    edit_nx  = time_set;
    case (state)
      IDLE: begin
        if (btn_mode) begin
          edit_nx  = time_current;
          state_nx = EDIT_H;
        end
      end
      EDIT_H, EDIT_M, EDIT_S: begin
        if (btn_cancel) begin
          state_nx = IDLE;
        end else if (btn_mode) begin
          if (state == EDIT_H)      state_nx = EDIT_M;
          else if (state == EDIT_M) state_nx = EDIT_S;
          else                      state_nx = COMMIT;
        end else if (timeout_hit) begin
          state_nx = IDLE;
        end else if (state == EDIT_H) begin
          edit_nx[HOUR_HI:HOUR_LO] = hour_nx;
        end else if (state == EDIT_M) begin
          edit_nx[MIN_HI:MIN_LO] = min_nx;
        end else begin
          edit_nx[SEC_HI:SEC_LO] = sec_nx;
        end
      end
      COMMIT: begin
        if (ow_cnt == OW_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      time_set    <= '0;
      time_ow     <= 1'b0;
      field_sel   <= FSEL_NONE;
      edit_active <= 1'b0;
      ow_cnt      <= '0;
    end else begin
      state       <= state_nx;
      time_set    <= edit_nx;
      time_ow     <= (state_nx == COMMIT);
      field_sel   <= field_of(state_nx);
      edit_active <= is_edit(state_nx);
      ow_cnt      <= (state == COMMIT) ? ow_cnt + OW_W'(1) : '0;
    end
  end

  assign time_disp = (state != IDLE) ? time_set : time_current;

endmodule

`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_clock_set_ctrl: scoreboard bench with a field-level time model   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_clock_set_ctrl;

  localparam int OW_CYC = 4;
  localparam int TO_CYC = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_cancel = 1'b0;
  logic [16:0] tcur = '0;
  logic [16:0] time_set, time_disp;
  logic        time_ow, edit_active;
  logic [1:0]  field_sel;

  clock_set_ctrl #(.OW_CYC(OW_CYC), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_mode     (btn_mode),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_cancel   (btn_cancel),
    .time_current (tcur),
    .time_set     (time_set),
    .time_ow      (time_ow),
    .time_disp    (time_disp),
    .field_sel    (field_sel),
    .edit_active  (edit_active)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1..3 editing hour/min/sec, 4 committing.
  int ph = 0;
  int fv[1:3] = '{0, 0, 0};
  int cc = 0;
  int ic = 0;
  logic [16:0] exp_q[$];

  function automatic logic [16:0] pk(input int h, input int m, input int s);
    logic [16:0] r;
    r = {h[4:0], m[5:0], s[5:0]};
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; cc = 0; ic = 0;
    fv[1] = 0; fv[2] = 0; fv[3] = 0;
  endtask

  task automatic model(input bit m, input bit u, input bit d, input bit c);
    int mx;
    case (ph)
      0: if (m) begin
        fv[1] = int'(tcur[16:12]); fv[2] = int'(tcur[11:6]); fv[3] = int'(tcur[5:0]);
        ph = 1; ic = 0;
      end
      1, 2, 3: begin
        mx = (ph == 1) ? 23 : 59;
        if (c) ph = 0;
        else if (m) begin
          ph++;
          ic = 0;
          if (ph == 4) begin
            exp_q.push_back(pk(fv[1], fv[2], fv[3]));
            cc = 0;
          end
        end else if (u || d) begin
          ic = 0;
          if (u && !d)      fv[ph] = (fv[ph] >= mx) ? 0 : fv[ph] + 1;
          else if (d && !u) fv[ph] = (fv[ph] == 0 || fv[ph] > mx) ? mx : fv[ph] - 1;
        end else begin
`ifdef CLOCK_SET_TIMEOUT_EN
          ic++;
          if (ic == TO_CYC) ph = 0;
`endif
        end
      end
      default: begin
        cc++;
        if (cc == OW_CYC) ph = 0;
      end
    endcase
  endtask

  task automatic step(input bit m, input bit u, input bit d, input bit c);
    logic [16:0] ets;
    btn_mode = m; btn_up = u; btn_down = d; btn_cancel = c;
    @(posedge clk);
    #1;
    btn_mode = 0; btn_up = 0; btn_down = 0; btn_cancel = 0;
    model(m, u, d, c);
    ets = pk(fv[1], fv[2], fv[3]);
    chk("edit_active", 32'(edit_active), 32'(ph >= 1 && ph <= 3));
    chk("field_sel", 32'(field_sel), (ph >= 1 && ph <= 3) ? ph : 0);
    chk("time_set", 32'(time_set), 32'(ets));
    chk("time_ow", 32'(time_ow), 32'(ph == 4));
    chk("time_disp", 32'(time_disp), 32'((ph != 0) ? ets : tcur));
  endtask

  // Monitor: each strobe pops one committed value and must last OW_CYC cycles.
  bit          in_str = 0;
  int          olen = 0;
  logic [16:0] held = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        in_str = 0;
      end else if (time_ow) begin
        if (!in_str) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL strobe_unexpected: got time_ow=1 with value %0h expected no strobe", time_set);
          end else begin
            held = exp_q.pop_front();
            chk("commit_value", 32'(time_set), 32'(held));
          end
          in_str = 1;
          olen = 1;
        end else begin
          olen++;
          chk("commit_stable", 32'(time_set), 32'(held));
        end
      end else if (in_str) begin
        chk("strobe_len", olen, OW_CYC);
        in_str = 0;
      end
    end
  end

  initial begin
    rst = 1'b1;
    #12;
    chk("rst_time_set", 32'(time_set), 0);
    chk("rst_time_ow", 32'(time_ow), 0);
    chk("rst_edit_active", 32'(edit_active), 0);
    chk("rst_field_sel", 32'(field_sel), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Enter edit, hour wraps after 23.
    tcur = pk(10, 20, 30);
    step(1, 0, 0, 0);
    chk("enter_time_set", 32'(time_set), 32'(pk(10, 20, 30)));
    chk("enter_field_sel", 32'(field_sel), 1);
    for (int i = 0; i < 14; i++) step(0, 1, 0, 0);
    chk("hour_wrap", 32'(time_set), 32'(pk(0, 20, 30)));

    // Minute underflow, then simultaneous up/down.
    step(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("min_underflow", 32'(time_set), 32'(pk(0, 59, 30)));
    step(0, 1, 1, 0);
    chk("min_updown", 32'(time_set), 32'(pk(0, 59, 30)));

    // Cancel from EDIT_S: no strobe, display follows the counter.
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("cancel_edit_active", 32'(edit_active), 0);
    tcur = pk(1, 2, 3);
    step(0, 0, 0, 0);
    chk("cancel_disp", 32'(time_disp), 32'(pk(1, 2, 3)));

    // Full commit of 07:45:59.
    tcur = pk(7, 45, 59);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    for (int i = 0; i < OW_CYC + 3; i++) step(0, 0, 0, 0);
    chk("commit_hold", 32'(time_set), 32'(pk(7, 45, 59)));

    // Randomized sessions, including out-of-range captures.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0)
        tcur = pk($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
      step($urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < OW_CYC + 2; i++) step(0, 0, 0, 0);

    // Asynchronous reset during the second commit cycle.
    tcur = pk(3, 4, 5);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_commit_ow", 32'(time_ow), 0);
    chk("rst_commit_set", 32'(time_set), 0);
    chk("rst_commit_disp", 32'(time_disp), 32'(pk(3, 4, 5)));
    @(negedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(0, 0, 0, 0);

`ifdef CLOCK_SET_TIMEOUT_EN
    step(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0);
    chk("timeout_restart", 32'(edit_active), 1);
    step(0, 0, 0, 0);
    chk("timeout_abort", 32'(edit_active), 0);
    chk("timeout_no_ow", 32'(time_ow), 0);
`endif

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
